// File: rtl/ps2_key_tx_pkg.sv
// Shared types and constants for the PS/2 key-event transmitter.
// Host-inhibit detection is compiled in with PS2_KEY_TX_INHIBIT_EN.
package ps2_key_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    GAP
  } state_t;

  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] BYTE_BRK   = 8'hF0;
  localparam int         FRAME_BITS = 11;

  // Bytes of one key event, first byte to send in bits [7:0].
  typedef struct packed {
    logic [1:0]  cnt;
    logic [23:0] bytes;
  } evt_bytes_t;

  function automatic evt_bytes_t build_event(input logic ext, input logic pressed,
                                             input logic [7:0] code);
    evt_bytes_t e;
    e.cnt   = 2'd0;
    e.bytes = '0;
    if (ext) begin
      e.bytes[7:0] = BYTE_EXT;
      e.cnt        = 2'd1;
    end
    if (!pressed) begin
      e.bytes[8*e.cnt +: 8] = BYTE_BRK;
      e.cnt                 = e.cnt + 2'd1;
    end
    e.bytes[8*e.cnt +: 8] = code;
    e.cnt                 = e.cnt + 2'd1;
    return e;
  endfunction

endpackage

// File: rtl/ps2_key_tx_fifo.sv
// Byte queue that accepts up to three bytes per push and pops one at a time.
// DEPTH must be a power of two so the pointers wrap naturally.
module ps2_key_tx_fifo
  import ps2_key_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   push,
  input  logic [1:0]             push_cnt,
  input  logic [23:0]            push_data,
  input  logic                   pop,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] free
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign free    = CW'(DEPTH) - count;
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(push_cnt);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (push ? CW'(push_cnt) : CW'(0)) - CW'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      for (int i = 0; i < 3; i++) begin
        if (2'(i) < push_cnt) mem[wr_ptr + AW'(i)] <= push_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ps2_key_tx.sv
// Turns ps2_key toggle events into PS/2 device-to-host frames on open-drain lines.
// Define PS2_KEY_TX_INHIBIT_EN to abort and retransmit when the host holds the clock low.
module ps2_key_tx
  import ps2_key_tx_pkg::*;
#(
  parameter int HALF_PERIOD = 2000,
  parameter int GAP_CYCLES  = 4000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic        ps2_clk_out,
  output logic        ps2_dat_out,
  output logic        busy,
  output logic        drop
);

  localparam int CNT_W = $clog2(HALF_PERIOD);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] half_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [3:0]       bit_idx;
  logic [10:0]      frame_q;
  logic [7:0]       cur_byte;
  logic             retry_q;
  logic             strobe_q;
  logic             drop_q;

  logic             key_evt, push_ok, pop;
  evt_bytes_t       evt;
  logic [7:0]       fifo_rd, load_byte;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_free;
  logic             half_done, gap_done, last_bit;
  logic             line_free, host_inhibit;
  logic             unused_inputs;

  assign unused_inputs = ^{ps2_dat_in, ps2_clk_in};

`ifdef PS2_KEY_TX_INHIBIT_EN
  assign line_free    = ps2_clk_in;
  assign host_inhibit = !ps2_clk_in && !last_bit;
`else
  assign line_free    = 1'b1;
  assign host_inhibit = 1'b0;
`endif

  // An event is all-or-nothing: it needs room for every one of its bytes.
  assign key_evt = ps2_key[10] ^ strobe_q;
  assign evt     = build_event(ps2_key[8], ps2_key[9], ps2_key[7:0]);
  assign push_ok = key_evt && (fifo_free >= CW'(evt.cnt));

  always_ff @(posedge clk_sys) begin
    strobe_q <= ps2_key[10];
    drop_q   <= reset ? 1'b0 : (key_evt && !push_ok);
  end

  ps2_key_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push_ok),
    .push_cnt  (evt.cnt),
    .push_data (evt.bytes),
    .pop       (pop),
    .rd_data   (fifo_rd),
    .empty     (fifo_empty),
    .free      (fifo_free)
  );

  assign half_done = (half_cnt == CNT_W'(HALF_PERIOD - 1));
  assign gap_done  = line_free && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign last_bit  = (bit_idx == 4'(FRAME_BITS - 1));
  assign load_byte = retry_q ? cur_byte : fifo_rd;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty && line_free) state_d = LOAD;
      LOAD: begin
        state_d = HIGH;
        pop     = !retry_q;
      end
      HIGH: begin
        if (host_inhibit)   state_d = GAP;
        else if (half_done) state_d = LOW;
      end
      LOW:  if (half_done) state_d = last_bit ? GAP : HIGH;
      GAP:  if (gap_done) state_d = retry_q ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      half_cnt <= '0;
      gap_cnt  <= '0;
      bit_idx  <= '0;
      frame_q  <= '1;
      cur_byte <= '0;
      retry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_cnt <= '0;
      case (state_q)
        LOAD: begin
          cur_byte <= load_byte;
          frame_q  <= {1'b1, ~^load_byte, load_byte, 1'b0};
          bit_idx  <= '0;
          half_cnt <= '0;
          retry_q  <= 1'b0;
        end
        HIGH: begin
          if (host_inhibit) retry_q <= 1'b1;
          half_cnt <= half_done ? '0 : half_cnt + CNT_W'(1);
        end
        LOW: begin
          half_cnt <= half_done ? '0 : half_cnt + CNT_W'(1);
          if (half_done && !last_bit) begin
            bit_idx <= bit_idx + 4'd1;
            frame_q <= {1'b1, frame_q[10:1]};
          end
        end
        // Host holding the clock low restarts the quiet-time count.
        GAP: gap_cnt <= line_free ? gap_cnt + GAP_W'(1) : '0;
        default: ;
      endcase
    end
  end

  assign ps2_clk_out = reset || (state_q != LOW);
  assign ps2_dat_out = reset || !((state_q == HIGH) || (state_q == LOW)) || frame_q[0];
  assign busy        = !reset && (!fifo_empty || (state_q != IDLE));
  assign drop        = drop_q && !reset;

endmodule

// File: tb/tb_ps2_key_tx.sv
// Scoreboard bench for ps2_key_tx: stimulus queues expected bytes, a frame
// monitor decodes the PS/2 lines and compares each completed frame.
module tb_ps2_key_tx;

  localparam int HP    = 4;
  localparam int GAP   = 10;
  localparam int DEPTH = 8;
  localparam int FRAME_LEN = 22 * HP + GAP + 2;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        ps2_clk_in, ps2_dat_in;
  logic        ps2_clk_out, ps2_dat_out, busy, drop;

  ps2_key_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_key     (ps2_key),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_dat_in  (ps2_dat_in),
    .ps2_clk_out (ps2_clk_out),
    .ps2_dat_out (ps2_dat_out),
    .busy        (busy),
    .drop        (drop)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t        exp_q[$];
  int          start_t[$];
  int          checks = 0;
  int          errors = 0;
  int          frames = 0;
  int          aborted = 0;
  int          drop_cnt = 0;
  int          mon_nbits = 0;
  int          cyc = 0;
  int          idle = 0;
  logic        prev_clk = 1'b1;
  logic [10:0] bits = '0;
  logic [10:0] last_bits = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic p);
    exp_t e;
    e.data = d;
    e.par  = p;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic wait_nbits(input string name, input int target);
    int n;
    n = 0;
    while (mon_nbits != target && n < 1000) begin
      tick();
      n++;
    end
    check(name, mon_nbits, target);
    n = 0;
    while (ps2_clk_out !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Frame monitor: samples data on every falling edge of ps2_clk_out.
  always @(negedge clk_sys) begin
    exp_t e;
    cyc++;
    if (prev_clk === 1'b1 && ps2_clk_out === 1'b0) begin
      idle = 0;
      if (mon_nbits == 0) start_t.push_back(cyc);
      bits[mon_nbits] = ps2_dat_out;
      mon_nbits++;
      if (mon_nbits == 11) begin
        mon_nbits = 0;
        last_bits = bits;
        frames++;
        check("start_bit", bits[0], 1'b0);
        check("stop_bit", bits[10], 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame got %0h expected none", bits[8:1]);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", bits[8:1], e.data);
          check("frame_parity", bits[9], e.par);
        end
      end
    end else if (ps2_clk_out === 1'b1) begin
      idle++;
      if (idle > HP + 2 && mon_nbits != 0) begin
        aborted++;
        mon_nbits = 0;
      end
    end
    prev_clk = ps2_clk_out;
    if (drop === 1'b1) drop_cnt++;
  end

  initial begin
    int cnt, f0, a0, d0;
    reset      = 1'b1;
    ps2_key    = '0;
    ps2_clk_in = 1'b1;
    ps2_dat_in = 1'b1;
    repeat (3) tick();
    check("rst_clk", ps2_clk_out, 1'b1);
    check("rst_dat", ps2_dat_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rst_busy", busy, 1'b0);

    // Press 0x1C: single frame, busy length covers frame, gap and two setup cycles.
    expect_byte(8'h1C, 1'b0);
    send_key(1'b1, 1'b0, 8'h1C);
    cnt = busy ? 1 : 0;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (busy) cnt++;
      else break;
    end
    check("t1_busy_len", cnt, FRAME_LEN);
    check("t1_sequence", last_bits, 11'h438);

    // Release of extended 0x75: E0, F0, 75 back to back.
    start_t.delete();
    expect_byte(8'hE0, 1'b0);
    expect_byte(8'hF0, 1'b1);
    expect_byte(8'h75, 1'b0);
    send_key(1'b0, 1'b1, 8'h75);
    wait_idle("t2_idle", 2000);
    check("t2_frames", start_t.size(), 3);
    if (start_t.size() >= 3) begin
      check("t2_spacing_a", start_t[1] - start_t[0], FRAME_LEN);
      check("t2_spacing_b", start_t[2] - start_t[1], FRAME_LEN);
    end

    // Three extended releases need 9 slots; the third is dropped.
    f0 = frames;
    d0 = drop_cnt;
    repeat (2) begin
      expect_byte(8'hE0, 1'b0);
      expect_byte(8'hF0, 1'b1);
      expect_byte(8'h75, 1'b0);
    end
    repeat (3) send_key(1'b0, 1'b1, 8'h75);
    wait_idle("t3_idle", 3000);
    check("t3_frames", frames - f0, 6);
    check("t3_drops", drop_cnt - d0, 1);

    // Host pulls ps2_clk low during bit 4.
    f0 = frames;
    a0 = aborted;
    expect_byte(8'h1C, 1'b0);
    send_key(1'b1, 1'b0, 8'h1C);
    wait_nbits("t4_reach_bit4", 4);
    ps2_clk_in = 1'b0;
    repeat (3) tick();
    check("t4_clk_released", ps2_clk_out, 1'b1);
    check("t4_dat_released", ps2_dat_out, 1'b1);
    repeat (5) tick();
    ps2_clk_in = 1'b1;
    wait_idle("t4_idle", 2000);
    check("t4_frames", frames - f0, 1);
`ifdef PS2_KEY_TX_INHIBIT_EN
    check("t4_aborted", aborted - a0, 1);
`else
    check("t4_aborted", aborted - a0, 0);
`endif

    // Reset in the middle of bit 6 kills the frame and the byte.
    f0 = frames;
    send_key(1'b1, 1'b0, 8'h1C);
    wait_nbits("t5_reach_bit6", 6);
    reset = 1'b1;
    tick();
    check("t5_clk", ps2_clk_out, 1'b1);
    check("t5_dat", ps2_dat_out, 1'b1);
    check("t5_busy", busy, 1'b0);
    tick();
    reset = 1'b0;
    repeat (300) tick();
    check("t5_no_frame", frames - f0, 0);
    check("t5_busy_after", busy, 1'b0);

    // Strobe toggles during reset must not produce an event.
    f0 = frames;
    d0 = drop_cnt;
    reset = 1'b1;
    repeat (3) send_key(1'b1, 1'b0, 8'h1C);
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (busy) cnt++;
    end
    check("t6_busy_cycles", cnt, 0);
    check("t6_no_frame", frames - f0, 0);
    check("t6_no_drop", drop_cnt - d0, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_tx.md
PS2_KEY_TX -- requirements
Module: ps2_key_tx

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 2000, meaning clk_sys cycles per PS/2 clock half-period (12.5 kHz at 50 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 4000, meaning idle clk_sys cycles between consecutive frames.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the byte queue depth; it must be a power of two and at least 4.
REQ-004 SHALL have port `clk_sys`, input, 1 bit: the single clock.
REQ-005 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port `ps2_key`, input, 11 bits: [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode.
REQ-007 SHALL have port `ps2_clk_in`, input, 1 bit: sampled PS/2 clock line.
REQ-008 SHALL have port `ps2_dat_in`, input, 1 bit: sampled PS/2 data line (reserved; not used for function).
REQ-009 SHALL have port `ps2_clk_out`, output, 1 bit: open-drain clock drive, where 1 means released.
REQ-010 SHALL have port `ps2_dat_out`, output, 1 bit: open-drain data drive, where 1 means released.
REQ-011 SHALL have port `busy`, output, 1 bit: high while the FIFO is non-empty, a frame is in progress, or a gap is in progress.
REQ-012 SHALL have port `drop`, output, 1 bit: one-cycle pulse when a key event is discarded.

Function
REQ-013 SHALL detect an event when ps2_key[10] differs from its registered copy; the event is enqueued on the following cycle.
REQ-014 SHALL enqueue, in order: 8'hE0 if extended; 8'hF0 if not pressed; then the scancode.
REQ-015 SHALL enqueue all bytes of an event, or none of them: if free slots are fewer than the event's byte count, the event is discarded and drop pulses.
REQ-016 SHALL give a simultaneous enqueue and dequeue in the same cycle the correct occupancy; write and read pointers wrap modulo FIFO_DEPTH.
REQ-017 SHALL use the frame format: start 0, data[0..7] LSB first, odd parity bit, stop 1 (11 bits).
REQ-018 SHALL send each bit in two phases:
  - the data level is set at the start of a HALF_PERIOD-cycle high phase of ps2_clk_out;
  - ps2_clk_out is then low for HALF_PERIOD cycles.
  One frame therefore lasts 22*HALF_PERIOD cycles.
REQ-019 SHALL use the FSM states IDLE, LOAD, HIGH, LOW, GAP:
  - IDLE goes to LOAD when the FIFO is non-empty;
  - LOAD pops a byte, computes parity, clears the bit counter, and goes to HIGH after 1 cycle;
  - HIGH goes to LOW when its counter expires;
  - LOW goes to HIGH and increments the bit index, or goes to GAP after bit 10;
  - GAP goes to IDLE after GAP_CYCLES.
REQ-020 SHALL take 2 cycles from enqueue of the first byte (in IDLE) to ps2_dat_out falling for the start bit.
REQ-021 SHALL release both lines (output 1) in IDLE and GAP.
REQ-022 SHALL size the half-period counter at $clog2(HALF_PERIOD) bits and the bit index at 4 bits.

Reset
REQ-023 SHALL, while reset is high, force ps2_clk_out=1, ps2_dat_out=1, busy=0, drop=0, state=IDLE, and FIFO empty.
REQ-024 SHALL load the strobe copy from ps2_key[10] during reset, so that no event is generated at reset release.
REQ-025 SHALL, on reset asserted mid-frame, abort the frame within the same cycle edge and discard the byte.

Configuration
REQ-026 SHALL provide the macro PS2_KEY_TX_INHIBIT_EN to compile host-inhibit detection in or out.
REQ-027 SHALL, with PS2_KEY_TX_INHIBIT_EN defined, handle host inhibit as follows:
  - ps2_clk_in is sampled low during a HIGH phase before bit 10: the frame aborts, both lines are released, the popped byte is held, and the FSM waits in GAP until ps2_clk_in has been high for GAP_CYCLES;
  - it then retransmits the same byte from LOAD;
  - ps2_clk_in low in IDLE blocks leaving IDLE.
REQ-028 SHALL, without PS2_KEY_TX_INHIBIT_EN, ignore ps2_clk_in; frames always complete.

Structure
REQ-029 SHALL place the state enum, constants BYTE_EXT=8'hE0, BYTE_BRK=8'hF0, and FRAME_BITS=11 in package ps2_key_tx_pkg.
REQ-030 SHALL implement the byte queue as sub-module ps2_key_tx_fifo, with push/pop, free count, and synchronous reset.

Verification
REQ-031 SHALL cover press of 0x1C: the dat sequence at clk falls is 0,0,0,1,1,1,0,0,0,0,1; busy drops 22*HALF_PERIOD+GAP_CYCLES+2 cycles after the event.
REQ-032 SHALL cover release of extended 0x75: three frames E0 (parity 0), F0 (parity 1), 75 (parity 0), in order, each separated by GAP_CYCLES.
REQ-033 SHALL cover with FIFO_DEPTH=8: three extended releases fill 9 slots needed, so the third is dropped, drop pulses once, and exactly 6 frames are sent.
REQ-034 SHALL cover with the inhibit macro defined: ps2_clk_in is held low during bit 4 of 0x1C; the lines are released and, after ps2_clk_in is high for GAP_CYCLES, the full 0x1C frame repeats. Without the macro, the frame completes unchanged.
REQ-035 SHALL cover reset asserted at bit 6 of a frame: the next cycle shows ps2_clk_out=1, ps2_dat_out=1, busy=0, and no frame follows.
REQ-036 SHALL cover toggling ps2_key[10] during reset: no event is generated after release.
